// File: rtl/tc_encoder3_seq.sv
// 8-to-3 priority encoder with a one-entry valid/ready output register and a multi-hot error counter.
// Define TC_ENCODER3_ROUND_ROBIN_EN to replace fixed lowest-index priority with a rotating pointer.
module tc_encoder3_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dis,
  input  logic       in0,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3,
  input  logic       in4,
  input  logic       in5,
  input  logic       in6,
  input  logic       in7,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out0,
  output logic       out1,
  output logic       out2,
  output logic       out_zero,
  output logic       out_multi,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] err_count
);

  logic [7:0] vec;
  logic [2:0] win;
  logic [3:0] ones;
  logic       multi;
  logic       accept;
  logic       pop;

  logic       valid_q;
  logic [2:0] idx_q;
  logic       zero_q;
  logic       multi_q;
  logic [7:0] err_q;

  assign vec = {in7, in6, in5, in4, in3, in2, in1, in0};

  assign in_ready = !dis && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign pop      = valid_q && out_ready;

  always_comb begin
    ones = '0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + 4'(vec[i]);
    end
    multi = (ones >= 4'd2);
  end

`ifdef TC_ENCODER3_ROUND_ROBIN_EN
  logic [2:0] ptr_q;
  logic [2:0] cand;

  // Scan downwards so the last hit is the one closest to the pointer.
  always_comb begin
    win  = '0;
    cand = '0;
    for (int j = 7; j >= 0; j--) begin
      cand = ptr_q + 3'(j);
      if (vec[cand]) win = cand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (accept && (vec != 8'd0)) begin
      ptr_q <= win + 3'd1;
    end
  end
`else
  always_comb begin
    win = '0;
    for (int j = 7; j >= 0; j--) begin
      if (vec[j]) win = 3'(j);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      zero_q  <= 1'b0;
      multi_q <= 1'b0;
      err_q   <= '0;
    end else begin
      if (accept) begin
        valid_q <= 1'b1;
        idx_q   <= win;
        zero_q  <= (vec == 8'd0);
        multi_q <= multi;
        if (multi && (err_q != 8'hff)) err_q <= err_q + 8'd1;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out0      = idx_q[0];
  assign out1      = idx_q[1];
  assign out2      = idx_q[2];
  assign out_zero  = zero_q;
  assign out_multi = multi_q;
  assign out_valid = valid_q;
  assign err_count = err_q;

endmodule
